// File: rtl/mem_stage_lsu.sv
// Memory stage between execute and writeback: one bus request per load/store, store lane/strobe
// alignment, load extraction/extension. Optional macro MEM_STAGE_MISALIGN_EXC_EN raises out_exc on misaligned access.
module mem_stage_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_pc,
  input  logic [1:0]            in_op,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [DATA_W-1:0]     in_result,
  input  logic                  in_wb_en,
  input  logic [REG_W-1:0]      in_dst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     out_pc,
  output logic [DATA_W-1:0]     out_result,
  output logic                  out_wb_en,
  output logic [REG_W-1:0]      out_dst,
  output logic                  out_exc,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_W-1:0]     req_addr,
  output logic [DATA_W/8-1:0]   req_wstrb,
  output logic [DATA_W-1:0]     req_wdata,
  input  logic                  resp_valid,
  input  logic [DATA_W-1:0]     resp_data
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam logic [DATA_W-1:0] MASK_B = DATA_W'(8'hFF);
  localparam logic [DATA_W-1:0] MASK_H = DATA_W'(16'hFFFF);
  localparam logic [DATA_W-1:0] MASK_W = DATA_W'(32'hFFFF_FFFF);

  typedef enum logic [2:0] {S_EMPTY, S_REQ, S_RESP, S_DONE, S_DRAIN} state_t;
  state_t state_reg, state_next;

  logic              accept, is_mem, fault;
  logic [1:0]        size_eff;
  logic [OFF_W-1:0]  size_mask, off_al;
  logic [STRB_W-1:0] wstrb_calc;
  logic [DATA_W-1:0] wdata_rep, lane, ext_mask, load_ext;
  logic              ext_sign;

  logic [ADDR_W-1:0] pc_reg, req_addr_reg;
  logic [DATA_W-1:0] result_reg, req_wdata_reg;
  logic [STRB_W-1:0] req_wstrb_reg;
  logic [REG_W-1:0]  dst_reg;
  logic              wb_en_reg, exc_reg, load_reg, uns_reg;
  logic [1:0]        size_reg;
  logic [OFF_W-1:0]  off_reg;

  // DWORD only exists on a 64-bit bus; on 32 bits it degrades to a word access
  assign size_eff  = (DATA_W == 32 && in_size == 2'd3) ? 2'd2 : in_size;
  assign size_mask = (OFF_W'(1) << size_eff) - OFF_W'(1);
  assign off_al    = in_addr[OFF_W-1:0] & ~size_mask;
  assign is_mem    = (in_op == 2'd1) || (in_op == 2'd2);

`ifdef MEM_STAGE_MISALIGN_EXC_EN
  assign fault = is_mem && ((in_addr[OFF_W-1:0] & size_mask) != '0);
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    wstrb_calc = '1;
    case (size_eff)
      2'd0:    wstrb_calc = STRB_W'(1) << off_al;
      2'd1:    wstrb_calc = STRB_W'(3) << off_al;
      2'd2:    wstrb_calc = STRB_W'(15) << off_al;
      default: wstrb_calc = '1;
    endcase
  end

  // Each byte lane takes the store byte that lands there when the datum is replicated
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      assign wdata_rep[8*gi +: 8] = (size_eff == 2'd0) ? in_wdata[7:0] :
                                    (size_eff == 2'd1) ? in_wdata[8*(gi%2) +: 8] :
                                    (size_eff == 2'd2) ? in_wdata[8*(gi%4) +: 8] :
                                                         in_wdata[8*gi +: 8];
    end
  endgenerate

  assign lane = resp_data >> {off_reg, 3'b000};
  always_comb begin
    ext_mask = '1;
    ext_sign = 1'b0;
    case (size_reg)
      2'd0:    begin ext_mask = MASK_B; ext_sign = lane[7];  end
      2'd1:    begin ext_mask = MASK_H; ext_sign = lane[15]; end
      2'd2:    begin ext_mask = MASK_W; ext_sign = lane[31]; end
      default: begin ext_mask = '1;     ext_sign = 1'b0;     end
    endcase
  end
  assign load_ext = (lane & ext_mask) | ((ext_sign && !uns_reg) ? ~ext_mask : '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_EMPTY;
    else         state_reg <= state_next;
  end

  assign accept = in_valid && in_ready && !flush;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_EMPTY: if (accept) state_next = (is_mem && !fault) ? S_REQ : S_DONE;
      // A flush racing the bus accept still owes us a response, so it must be drained
      S_REQ: begin
        if (flush)          state_next = req_ready ? S_DRAIN : S_EMPTY;
        else if (req_ready) state_next = S_RESP;
      end
      S_RESP: begin
        if (flush)           state_next = resp_valid ? S_EMPTY : S_DRAIN;
        else if (resp_valid) state_next = S_DONE;
      end
      S_DONE: begin
        if (flush)          state_next = S_EMPTY;
        else if (accept)    state_next = (is_mem && !fault) ? S_REQ : S_DONE;
        else if (out_ready) state_next = S_EMPTY;
      end
      S_DRAIN: if (resp_valid) state_next = S_EMPTY;
      default: state_next = S_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    req_valid = 1'b0;
    case (state_reg)
      S_EMPTY: in_ready = 1'b1;
      S_REQ:   req_valid = 1'b1;
      S_DONE:  begin out_valid = 1'b1; in_ready = out_ready; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_reg        <= '0;
      req_addr_reg  <= '0;
      result_reg    <= '0;
      req_wdata_reg <= '0;
      req_wstrb_reg <= '0;
      dst_reg       <= '0;
      wb_en_reg     <= 1'b0;
      exc_reg       <= 1'b0;
      load_reg      <= 1'b0;
      uns_reg       <= 1'b0;
      size_reg      <= '0;
      off_reg       <= '0;
    end else if (accept) begin
      pc_reg        <= in_pc;
      req_addr_reg  <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      result_reg    <= fault ? '0 : in_result;
      req_wdata_reg <= (in_op == 2'd2) ? wdata_rep : '0;
      req_wstrb_reg <= (in_op == 2'd2) ? wstrb_calc : '0;
      dst_reg       <= in_dst;
      wb_en_reg     <= in_wb_en && (in_op != 2'd2) && !fault;
      exc_reg       <= fault;
      load_reg      <= (in_op == 2'd1);
      uns_reg       <= in_unsigned;
      size_reg      <= size_eff;
      off_reg       <= off_al;
    end else if (state_reg == S_RESP && resp_valid && load_reg && !flush) begin
      result_reg    <= load_ext;
    end
  end

  assign out_pc     = pc_reg;
  assign out_result = result_reg;
  assign out_wb_en  = wb_en_reg;
  assign out_dst    = dst_reg;
  assign out_exc    = exc_reg;
  assign req_addr   = req_addr_reg;
  assign req_wstrb  = req_wstrb_reg;
  assign req_wdata  = req_wdata_reg;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: stimulus pushes expected bus requests and writeback results,
// independent monitors pop and compare on each handshake.
module tb_mem_stage_lsu;
  logic        clk = 1'b0, resetn = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_pc = '0, in_addr = '0, in_wdata = '0, in_result = '0;
  logic [1:0]  in_op = '0, in_size = '0;
  logic        in_unsigned = 1'b0, in_wb_en = 1'b0;
  logic [4:0]  in_dst = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_pc, out_result;
  logic        out_wb_en, out_exc;
  logic [4:0]  out_dst;
  logic        req_valid, req_ready = 1'b0;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .REG_W(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_result(in_result),
    .in_wb_en(in_wb_en), .in_dst(in_dst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_result(out_result),
    .out_wb_en(out_wb_en), .out_dst(out_dst), .out_exc(out_exc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wstrb(req_wstrb),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] result; logic wb_en; logic [4:0] dst; logic exc; bit chk_res; } out_t;
  typedef struct { logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata; bit chk_wdata; } req_t;
  out_t exp_out[$];
  req_t exp_req[$];
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Writeback and bus-request monitors
  always @(negedge clk) begin : mon
    out_t eo;
    req_t er;
    if (resetn) begin
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          tests++; fails++;
          $display("FAIL out_unexpected: got result 0x%0h pc 0x%0h, expected no output", out_result, out_pc);
        end else begin
          eo = exp_out.pop_front();
          $display("[TB] out pc=%h result=%h wb=%0d dst=%0d exc=%0d", out_pc, out_result, out_wb_en, out_dst, out_exc);
          chk("out_pc", out_pc, eo.pc);
          if (eo.chk_res) chk("out_result", out_result, eo.result);
          chk("out_wb_en", 32'(out_wb_en), 32'(eo.wb_en));
          chk("out_dst", 32'(out_dst), 32'(eo.dst));
          chk("out_exc", 32'(out_exc), 32'(eo.exc));
        end
      end
      if (req_valid && req_ready) begin
        if (exp_req.size() == 0) begin
          tests++; fails++;
          $display("FAIL req_unexpected: got addr 0x%0h, expected no request", req_addr);
        end else begin
          er = exp_req.pop_front();
          $display("[TB] req addr=%h wstrb=%b wdata=%h", req_addr, req_wstrb, req_wdata);
          chk("req_addr", req_addr, er.addr);
          chk("req_wstrb", 32'(req_wstrb), 32'(er.wstrb));
          if (er.chk_wdata) chk("req_wdata", req_wdata, er.wdata);
        end
      end
    end
  end

  task automatic push_out(input logic [31:0] pc, res, input logic wb, input logic [4:0] dst, input logic exc, input bit cr);
    out_t e;
    e.pc = pc; e.result = res; e.wb_en = wb; e.dst = dst; e.exc = exc; e.chk_res = cr;
    exp_out.push_back(e);
  endtask

  task automatic push_req(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd, input bit cw);
    req_t e;
    e.addr = addr; e.wstrb = strb; e.wdata = wd; e.chk_wdata = cw;
    exp_req.push_back(e);
  endtask

  // Present one instruction and hold it until accepted; returns 1 ns after the accepting edge
  task automatic send(input logic [1:0] op, size, input logic uns, input logic [31:0] addr, wdata, result,
                      input logic wb, input logic [4:0] dst, input logic [31:0] pc);
    int k;
    in_op = op; in_size = size; in_unsigned = uns; in_addr = addr; in_wdata = wdata;
    in_result = result; in_wb_en = wb; in_dst = dst; in_pc = pc; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    chk("send_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Bus side: hold req_ready low for 'stall' cycles, accept, then return rdata next cycle
  task automatic bus(input int stall, input logic [31:0] rdata);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_req_valid", 32'(req_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (exp_req.size() > 0) begin
        chk("stall_req_addr", req_addr, exp_req[0].addr);
        chk("stall_req_wstrb", 32'(req_wstrb), 32'(exp_req[0].wstrb));
      end
      @(posedge clk); #1;
    end
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0; resp_valid = 1'b1; resp_data = rdata;
    @(posedge clk); #1;
    resp_valid = 1'b0; resp_data = '0;
  endtask

  task automatic mem_op(input logic [1:0] op, size, input logic uns, input logic [31:0] addr, wdata, pc,
                        input logic [31:0] x_addr, input logic [3:0] x_strb, input logic [31:0] x_wdata,
                        input logic [31:0] rdata, x_res, input logic x_wb, input int stall);
    push_req(x_addr, x_strb, x_wdata, op == 2'd2);
    push_out(pc, x_res, x_wb, 5'd9, 1'b0, 1'b1);
    send(op, size, uns, addr, wdata, 32'h55, 1'b1, 5'd9, pc);
    bus(stall, rdata);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    chk("rst_out_exc", 32'(out_exc), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // op size uns addr wdata pc | req addr strb wdata | rdata result wb stall
    mem_op(2'd1, 2'd2, 1'b0, 32'h100, 32'h0, 32'h1000, 32'h100, 4'b0000, 32'h0, 32'h8000_00FF, 32'h8000_00FF, 1'b1, 0);
    mem_op(2'd1, 2'd0, 1'b0, 32'h103, 32'h0, 32'h1004, 32'h100, 4'b0000, 32'h0, 32'h8012_3456, 32'hFFFF_FF80, 1'b1, 0);
    mem_op(2'd1, 2'd0, 1'b1, 32'h103, 32'h0, 32'h1008, 32'h100, 4'b0000, 32'h0, 32'h8012_3456, 32'h0000_0080, 1'b1, 0);
    mem_op(2'd1, 2'd1, 1'b0, 32'h102, 32'h0, 32'h100C, 32'h100, 4'b0000, 32'h0, 32'h8012_3456, 32'hFFFF_8012, 1'b1, 0);
    mem_op(2'd1, 2'd1, 1'b1, 32'h102, 32'h0, 32'h1010, 32'h100, 4'b0000, 32'h0, 32'h8012_3456, 32'h0000_8012, 1'b1, 1);
    mem_op(2'd1, 2'd0, 1'b0, 32'h101, 32'h0, 32'h1014, 32'h100, 4'b0000, 32'h0, 32'h0000_7F00, 32'h0000_007F, 1'b1, 0);
    mem_op(2'd2, 2'd0, 1'b0, 32'h201, 32'hAB, 32'h1018, 32'h200, 4'b0010, 32'hABAB_ABAB, 32'h0, 32'h55, 1'b0, 0);
    mem_op(2'd2, 2'd1, 1'b0, 32'h202, 32'h1234, 32'h101C, 32'h200, 4'b1100, 32'h1234_1234, 32'h0, 32'h55, 1'b0, 0);
    mem_op(2'd2, 2'd2, 1'b0, 32'h204, 32'hDEAD_BEEF, 32'h1020, 32'h204, 4'b1111, 32'hDEAD_BEEF, 32'h0, 32'h55, 1'b0, 4);

`ifdef MEM_STAGE_MISALIGN_EXC_EN
    push_out(32'h1024, 32'h0, 1'b0, 5'd9, 1'b1, 1'b0);
    send(2'd1, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 5'd9, 32'h1024);
    @(negedge clk);
    chk("mis_req_valid", 32'(req_valid), 32'd0);
    chk("mis_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
`else
    mem_op(2'd1, 2'd2, 1'b0, 32'h102, 32'h0, 32'h1024, 32'h100, 4'b0000, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 0);
    mem_op(2'd1, 2'd1, 1'b0, 32'h103, 32'h0, 32'h1028, 32'h100, 4'b0000, 32'h0, 32'h8012_3456, 32'hFFFF_8012, 1'b1, 0);
`endif

    // Back-to-back ALU results, one per cycle
    for (int i = 0; i < 3; i++) begin
      in_op = 2'd0; in_size = 2'd0; in_addr = '0; in_wdata = '0;
      in_pc = 32'h2000 + 32'(4 * i); in_result = 32'd100 + 32'(i); in_dst = 5'(i + 1); in_wb_en = 1'b1;
      push_out(in_pc, in_result, 1'b1, in_dst, 1'b0, 1'b1);
      in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_last_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Flush in REQ before the bus accepts: no request, no result
    send(2'd1, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 1'b1, 5'd3, 32'h3000);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("freq_req_valid", 32'(req_valid), 32'd0);
    chk("freq_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Flush in RESP: drain the outstanding response silently
    push_req(32'h304, 4'b0000, 32'h0, 1'b0);
    send(2'd1, 2'd2, 1'b0, 32'h304, 32'h0, 32'h0, 1'b1, 5'd4, 32'h3004);
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_in_ready2", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    resp_valid = 1'b1; resp_data = 32'h1234_5678;
    @(negedge clk);
    chk("drain_resp_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    chk("drain_done_in_ready", 32'(in_ready), 32'd1);
    chk("drain_done_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Flush in DONE while writeback is stalled
    out_ready = 1'b0;
    send(2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h77, 1'b1, 5'd6, 32'h3008);
    @(negedge clk);
    chk("fdone_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("fdone_after_out_valid", 32'(out_valid), 32'd0);
    chk("fdone_after_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RESP
    push_req(32'h400, 4'b0000, 32'h0, 1'b0);
    send(2'd1, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 5'd7, 32'h3010);
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    #3 resetn = 1'b0;
    #1;
    chk("arst_out_pc", out_pc, 32'd0);
    chk("arst_req_addr", req_addr, 32'd0);
    chk("arst_req_valid", 32'(req_valid), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_dst", 32'(out_dst), 32'd0);
    chk("arst_out_wb_en", 32'(out_wb_en), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    chk("exp_out_empty", 32'(exp_out.size()), 32'd0);
    chk("exp_req_empty", 32'(exp_req.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
